// File: rtl/gps_ubx_parser.sv
`default_nettype none
// ============================================================================
// Module   : gps_ubx_parser
// Purpose  : Frames UBX packets from the GPS UART byte stream and checks the
//            Fletcher checksum. Decodes NAV-POSLLH, NAV-VELNED and ACK-ACK/NAK.
// Revision : 1.0 - initial release
// ============================================================================
module gps_ubx_parser #(
   parameter int MAX_LEN = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        posllh_valid,
   output logic [31:0] lon,
   output logic [31:0] lat,
   output logic [31:0] hmsl,
   output logic        velned_valid,
   output logic [31:0] vel_n,
   output logic [31:0] vel_e,
   output logic [31:0] vel_d,
   output logic [31:0] gspeed,
   output logic        ack_valid,
   output logic        ack_nak,
   output logic [7:0]  ack_class,
   output logic [7:0]  ack_id,
   output logic        cksum_err,
   output logic        frame_err
);

   localparam logic [3:0] S_SYNC1   = 4'd0;
   localparam logic [3:0] S_SYNC2   = 4'd1;
   localparam logic [3:0] S_CLASS   = 4'd2;
   localparam logic [3:0] S_ID      = 4'd3;
   localparam logic [3:0] S_LEN_L   = 4'd4;
   localparam logic [3:0] S_LEN_H   = 4'd5;
   localparam logic [3:0] S_PAYLOAD = 4'd6;
   localparam logic [3:0] S_CK_A    = 4'd7;
   localparam logic [3:0] S_CK_B    = 4'd8;

   localparam logic [15:0] c_max_len = 16'(MAX_LEN);

   logic [3:0]  r_state;
   logic [3:0]  w_state_nxt;
   logic [7:0]  r_class;
   logic [7:0]  r_id;
   logic [15:0] r_len;
   logic [15:0] r_cnt;
   logic [7:0]  r_ck_a;
   logic [7:0]  r_ck_b;
   logic        r_ok_a;

   logic [31:0] r_sh_lon, r_sh_lat, r_sh_hmsl;
   logic [31:0] r_sh_vn, r_sh_ve, r_sh_vd, r_sh_gs;
   logic [7:0]  r_sh_acls, r_sh_aid;

   logic [15:0] w_len;
   logic [7:0]  w_ck_a_nxt;
   logic [7:0]  w_ck_b_nxt;
   logic [4:0]  w_bsel;
   logic        w_hdr_pos, w_hdr_vel, w_hdr_ack;
   logic        w_frame_err, w_cksum_err, w_ck_good;
   logic        w_commit_pos, w_commit_vel, w_commit_ack;

   assign w_len      = {rx_data, r_len[7:0]};
   assign w_ck_a_nxt = r_ck_a + rx_data;
   assign w_ck_b_nxt = r_ck_b + w_ck_a_nxt;
   // Every captured field starts on a 4-byte boundary, so the low counter bits pick the byte lane.
   assign w_bsel     = {r_cnt[1:0], 3'b000};
   assign w_hdr_pos  = (r_class == 8'h01) && (r_id == 8'h02);
   assign w_hdr_vel  = (r_class == 8'h01) && (r_id == 8'h12);
   assign w_hdr_ack  = (r_class == 8'h05) && ((r_id == 8'h01) || (r_id == 8'h00));

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_SYNC1;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (rx_valid) begin
         case (r_state)
            S_SYNC1:   if (rx_data == 8'hB5) w_state_nxt = S_SYNC2;
            S_SYNC2: begin
               if (rx_data == 8'h62)      w_state_nxt = S_CLASS;
               else if (rx_data == 8'hB5) w_state_nxt = S_SYNC2;
               else                       w_state_nxt = S_SYNC1;
            end
            S_CLASS:   w_state_nxt = S_ID;
            S_ID:      w_state_nxt = S_LEN_L;
            S_LEN_L:   w_state_nxt = S_LEN_H;
            S_LEN_H: begin
               if (w_len > c_max_len)  w_state_nxt = S_SYNC1;
               else if (w_len == 16'd0) w_state_nxt = S_CK_A;
               else                     w_state_nxt = S_PAYLOAD;
            end
            S_PAYLOAD: if (r_cnt == r_len - 16'd1) w_state_nxt = S_CK_A;
            S_CK_A:    w_state_nxt = S_CK_B;
            S_CK_B:    w_state_nxt = S_SYNC1;
            default:   w_state_nxt = S_SYNC1;
         endcase
      end
   end

   // Output decode: frame-level events seen on the accepting byte
   always_comb begin
      w_frame_err  = rx_valid && (r_state == S_LEN_H) && (w_len > c_max_len);
      w_ck_good    = rx_valid && (r_state == S_CK_B) && r_ok_a && (rx_data == r_ck_b);
      w_cksum_err  = rx_valid && (r_state == S_CK_B) && !(r_ok_a && (rx_data == r_ck_b));
      w_commit_pos = w_ck_good && w_hdr_pos && (r_len == 16'd28);
      w_commit_vel = w_ck_good && w_hdr_vel && (r_len == 16'd36);
      w_commit_ack = w_ck_good && w_hdr_ack && (r_len == 16'd2);
   end

   // Frame datapath: header, checksum, counter and payload shadow
   always_ff @(posedge clk) begin
      if (rst) begin
         r_class   <= 8'h00;
         r_id      <= 8'h00;
         r_len     <= 16'h0000;
         r_cnt     <= 16'h0000;
         r_ck_a    <= 8'h00;
         r_ck_b    <= 8'h00;
         r_ok_a    <= 1'b0;
         r_sh_lon  <= 32'h0;
         r_sh_lat  <= 32'h0;
         r_sh_hmsl <= 32'h0;
         r_sh_vn   <= 32'h0;
         r_sh_ve   <= 32'h0;
         r_sh_vd   <= 32'h0;
         r_sh_gs   <= 32'h0;
         r_sh_acls <= 8'h00;
         r_sh_aid  <= 8'h00;
      end else if (rx_valid) begin
         case (r_state)
            S_SYNC2: if (rx_data == 8'h62) begin
               r_ck_a <= 8'h00;
               r_ck_b <= 8'h00;
            end
            S_CLASS, S_ID, S_LEN_L, S_LEN_H, S_PAYLOAD: begin
               r_ck_a <= w_ck_a_nxt;
               r_ck_b <= w_ck_b_nxt;
               if (r_state == S_CLASS) r_class <= rx_data;
               if (r_state == S_ID)    r_id    <= rx_data;
               if (r_state == S_LEN_L) r_len   <= {8'h00, rx_data};
               if (r_state == S_LEN_H) begin
                  r_len <= w_len;
                  r_cnt <= 16'h0000;
               end
               if (r_state == S_PAYLOAD) begin
                  r_cnt <= r_cnt + 16'd1;
                  if (w_hdr_pos) begin
                     case (r_cnt[15:2])
                        14'd1:   r_sh_lon[w_bsel +: 8]  <= rx_data;
                        14'd2:   r_sh_lat[w_bsel +: 8]  <= rx_data;
                        14'd4:   r_sh_hmsl[w_bsel +: 8] <= rx_data;
                        default: ;
                     endcase
                  end
                  if (w_hdr_vel) begin
                     case (r_cnt[15:2])
                        14'd1:   r_sh_vn[w_bsel +: 8] <= rx_data;
                        14'd2:   r_sh_ve[w_bsel +: 8] <= rx_data;
                        14'd3:   r_sh_vd[w_bsel +: 8] <= rx_data;
                        14'd5:   r_sh_gs[w_bsel +: 8] <= rx_data;
                        default: ;
                     endcase
                  end
                  if (w_hdr_ack && (r_cnt == 16'd0)) r_sh_acls <= rx_data;
                  if (w_hdr_ack && (r_cnt == 16'd1)) r_sh_aid  <= rx_data;
               end
            end
            S_CK_A:  r_ok_a <= (rx_data == r_ck_a);
            default: ;
         endcase
      end
   end

   // Committed outputs and one-cycle strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         posllh_valid <= 1'b0;
         velned_valid <= 1'b0;
         ack_valid    <= 1'b0;
         cksum_err    <= 1'b0;
         frame_err    <= 1'b0;
         lon          <= 32'h0;
         lat          <= 32'h0;
         hmsl         <= 32'h0;
         vel_n        <= 32'h0;
         vel_e        <= 32'h0;
         vel_d        <= 32'h0;
         gspeed       <= 32'h0;
         ack_nak      <= 1'b0;
         ack_class    <= 8'h00;
         ack_id       <= 8'h00;
      end else begin
         posllh_valid <= w_commit_pos;
         velned_valid <= w_commit_vel;
         ack_valid    <= w_commit_ack;
         cksum_err    <= w_cksum_err;
         frame_err    <= w_frame_err;
         if (w_commit_pos) begin
            lon  <= r_sh_lon;
            lat  <= r_sh_lat;
            hmsl <= r_sh_hmsl;
         end
         if (w_commit_vel) begin
            vel_n  <= r_sh_vn;
            vel_e  <= r_sh_ve;
            vel_d  <= r_sh_vd;
            gspeed <= r_sh_gs;
         end
         if (w_commit_ack) begin
            ack_nak   <= (r_id == 8'h00);
            ack_class <= r_sh_acls;
            ack_id    <= r_sh_aid;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gps_ubx_parser.sv
`default_nettype none
// Bench for gps_ubx_parser: table of frames plus hand sequences; expected
// strobe events and held outputs go to a queue, popped whenever a strobe fires.
module tb_gps_ubx_parser;

   localparam logic [4:0] EV_NONE = 5'b00000;
   localparam logic [4:0] EV_POS  = 5'b00001;
   localparam logic [4:0] EV_VEL  = 5'b00010;
   localparam logic [4:0] EV_ACK  = 5'b00100;
   localparam logic [4:0] EV_CK   = 5'b01000;
   localparam logic [4:0] EV_FR   = 5'b10000;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        posllh_valid, velned_valid, ack_valid, cksum_err, frame_err;
   logic [31:0] lon, lat, hmsl, vel_n, vel_e, vel_d, gspeed;
   logic        ack_nak;
   logic [7:0]  ack_class, ack_id;

   gps_ubx_parser #(.MAX_LEN(64)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .posllh_valid(posllh_valid), .lon(lon), .lat(lat), .hmsl(hmsl),
      .velned_valid(velned_valid), .vel_n(vel_n), .vel_e(vel_e), .vel_d(vel_d),
      .gspeed(gspeed), .ack_valid(ack_valid), .ack_nak(ack_nak),
      .ack_class(ack_class), .ack_id(ack_id), .cksum_err(cksum_err),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  cls;
      logic [7:0]  id;
      logic [15:0] len;
      logic [31:0] f0, f1, f2, f3;
      logic [15:0] ckx;
      int          gap;
      logic [4:0]  ev;
   } vec_t;

   typedef struct {
      logic [4:0]  ev;
      logic [31:0] lon, lat, hmsl, vn, ve, vd, gs;
      logic        nak;
      logic [7:0]  acls, aid;
   } exp_t;

   exp_t exp_q[$];
   exp_t m;          // reference copy of the held outputs
   vec_t tbl[12];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic model_reset();
      m = '{ev: EV_NONE, lon: 0, lat: 0, hmsl: 0, vn: 0, ve: 0, vd: 0, gs: 0,
            nak: 1'b0, acls: 8'h00, aid: 8'h00};
   endtask

   task automatic expect_ev(input logic [4:0] ev, input logic [7:0] id,
                            input logic [31:0] f0, f1, f2, f3);
      exp_t e;
      if (ev == EV_POS) begin m.lon = f0; m.lat = f1; m.hmsl = f2; end
      if (ev == EV_VEL) begin m.vn = f0; m.ve = f1; m.vd = f2; m.gs = f3; end
      if (ev == EV_ACK) begin m.nak = (id == 8'h00); m.acls = f0[7:0]; m.aid = f1[7:0]; end
      e = m;
      e.ev = ev;
      if (ev != EV_NONE) exp_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data  = $urandom_range(0, 255);
      if (gap > 0) repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
   endtask

   // Builds and sends a frame; payload filler is random so stray captures show up.
   task automatic send_frame(input logic [7:0] cls, id, input logic [15:0] len,
                             input logic [31:0] f0, f1, f2, f3,
                             input logic [15:0] ckx, input int gap, input int stop_after);
      logic [7:0] pl[$];
      logic [7:0] hdr[4];
      logic [7:0] a, b;
      int sent;
      pl = {};
      if (len <= 16'd64) for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom_range(0, 255)));
      for (int k = 0; k < 4; k++) begin
         if (cls == 8'h01 && id == 8'h02) begin
            if (4 + k < pl.size())  pl[4 + k]  = f0[8*k +: 8];
            if (8 + k < pl.size())  pl[8 + k]  = f1[8*k +: 8];
            if (16 + k < pl.size()) pl[16 + k] = f2[8*k +: 8];
         end
         if (cls == 8'h01 && id == 8'h12) begin
            if (4 + k < pl.size())  pl[4 + k]  = f0[8*k +: 8];
            if (8 + k < pl.size())  pl[8 + k]  = f1[8*k +: 8];
            if (12 + k < pl.size()) pl[12 + k] = f2[8*k +: 8];
            if (20 + k < pl.size()) pl[20 + k] = f3[8*k +: 8];
         end
      end
      if (cls == 8'h05 && pl.size() >= 2) begin pl[0] = f0[7:0]; pl[1] = f1[7:0]; end
      send_byte(8'hB5, gap);
      send_byte(8'h62, gap);
      hdr[0] = cls; hdr[1] = id; hdr[2] = len[7:0]; hdr[3] = len[15:8];
      a = 8'h00; b = 8'h00;
      for (int i = 0; i < 4; i++) begin
         a = a + hdr[i]; b = b + a;
         send_byte(hdr[i], gap);
      end
      if (len > 16'd64) return;
      sent = 0;
      foreach (pl[i]) begin
         if (stop_after >= 0 && sent == stop_after) return;
         a = a + pl[i]; b = b + a;
         send_byte(pl[i], gap);
         sent++;
      end
      send_byte(a ^ ckx[15:8], gap);
      send_byte(b ^ ckx[7:0], gap);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic check_held(input string tag);
      chk({tag, "_lon"}, lon, m.lon);
      chk({tag, "_lat"}, lat, m.lat);
      chk({tag, "_hmsl"}, hmsl, m.hmsl);
      chk({tag, "_vel"}, vel_n ^ vel_e ^ vel_d ^ gspeed, m.vn ^ m.ve ^ m.vd ^ m.gs);
      chk({tag, "_ack"}, {15'd0, ack_nak, ack_class, ack_id}, {15'd0, m.nak, m.acls, m.aid});
      chk({tag, "_strobes"}, {27'd0, frame_err, cksum_err, ack_valid, velned_valid, posllh_valid}, 32'd0);
   endtask

   // Scoreboard: every strobe cycle must match the oldest outstanding event.
   always @(negedge clk) begin
      logic [4:0] st;
      exp_t e;
      st = {frame_err, cksum_err, ack_valid, velned_valid, posllh_valid};
      if (st != 5'd0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", {27'd0, st}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("strobe", {27'd0, st}, {27'd0, e.ev});
            chk("lon", lon, e.lon);
            chk("lat", lat, e.lat);
            chk("hmsl", hmsl, e.hmsl);
            chk("vel_n", vel_n, e.vn);
            chk("vel_e", vel_e, e.ve);
            chk("vel_d", vel_d, e.vd);
            chk("gspeed", gspeed, e.gs);
            chk("ack", {15'd0, ack_nak, ack_class, ack_id}, {15'd0, e.nak, e.acls, e.aid});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{8'h05, 8'h01, 16'd2,  32'h06, 32'h01, 32'h0, 32'h0, 16'h0000, 0, EV_ACK};
      tbl[1]  = '{8'h05, 8'h00, 16'd2,  32'h06, 32'h01, 32'h0, 32'h0, 16'h0000, 0, EV_ACK};
      tbl[2]  = '{8'h01, 8'h02, 16'd28, 32'hF8A1B2C3, 32'h1A2B3C4D, 32'h0001E240, 32'h0, 16'h0000, 0, EV_POS};
      tbl[3]  = '{8'h01, 8'h02, 16'd28, 32'hF8A1B2C3, 32'h1A2B3C4D, 32'h0001E240, 32'h0, 16'h0000, 3, EV_POS};
      tbl[4]  = '{8'h05, 8'h01, 16'd2,  32'h55, 32'h77, 32'h0, 32'h0, 16'h0001, 0, EV_CK};
      tbl[5]  = '{8'h01, 8'h12, 16'd36, 32'hFFFFFF9C, 32'h00000123, 32'hFFFFFF00, 32'd250, 16'h0000, 0, EV_VEL};
      tbl[6]  = '{8'h01, 8'h02, 16'd28, 32'h11111111, 32'h22222222, 32'h33333333, 32'h0, 16'h0100, 0, EV_CK};
      tbl[7]  = '{8'h01, 8'h02, 16'd20, 32'h44444444, 32'h55555555, 32'h0, 32'h0, 16'h0000, 0, EV_NONE};
      tbl[8]  = '{8'h0A, 8'h04, 16'd0,  32'h0, 32'h0, 32'h0, 32'h0, 16'h0000, 0, EV_NONE};
      tbl[9]  = '{8'h01, 8'h12, 16'd64, 32'h66666666, 32'h77777777, 32'h88888888, 32'h9, 16'h0000, 0, EV_NONE};
      tbl[10] = '{8'h05, 8'h00, 16'd2,  32'h0B, 32'h24, 32'h0, 32'h0, 16'h0000, 2, EV_ACK};
      tbl[11] = '{8'h01, 8'h12, 16'd36, 32'h80000001, 32'h7FFFFFFE, 32'h00C0FFEE, 32'h12345678, 16'h0000, 1, EV_VEL};

      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      model_reset();
      idle(3);
      rst = 1'b0;
      idle(1);
      check_held("reset");

      foreach (tbl[i]) begin
         expect_ev(tbl[i].ev, tbl[i].id, tbl[i].f0, tbl[i].f1, tbl[i].f2, tbl[i].f3);
         send_frame(tbl[i].cls, tbl[i].id, tbl[i].len, tbl[i].f0, tbl[i].f1, tbl[i].f2,
                    tbl[i].f3, tbl[i].ckx, tbl[i].gap, -1);
         idle(3);
      end
      check_held("after_table");

      // Leading garbage, including a repeated sync byte, before a VELNED frame
      send_byte(8'h00, 0);
      send_byte(8'hB5, 0);
      expect_ev(EV_VEL, 8'h12, 32'hFFFFFF9C, 32'h00000010, 32'h00000020, 32'd250);
      send_frame(8'h01, 8'h12, 16'd36, 32'hFFFFFF9C, 32'h00000010, 32'h00000020, 32'd250, 16'h0, 0, -1);
      idle(3);

      // Oversized declared lengths, then a normal ACK must still decode
      expect_ev(EV_FR, 8'h00, 0, 0, 0, 0);
      send_frame(8'h01, 8'h02, 16'h0100, 0, 0, 0, 0, 16'h0, 0, -1);
      idle(2);
      expect_ev(EV_FR, 8'h00, 0, 0, 0, 0);
      send_frame(8'h01, 8'h02, 16'd65, 0, 0, 0, 0, 16'h0, 0, -1);
      expect_ev(EV_ACK, 8'h01, 32'h06, 32'h01, 0, 0);
      send_frame(8'h05, 8'h01, 16'd2, 32'h06, 32'h01, 0, 0, 16'h0, 0, -1);
      idle(3);

      // Reset in the middle of a POSLLH payload
      send_frame(8'h01, 8'h02, 16'd28, 32'hDEADBEEF, 32'hCAFEF00D, 32'h01020304, 0, 16'h0, 0, 10);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      model_reset();
      idle(1);
      check_held("midreset");
      expect_ev(EV_POS, 8'h02, 32'hF8A1B2C3, 32'h1A2B3C4D, 32'h0001E240, 0);
      send_frame(8'h01, 8'h02, 16'd28, 32'hF8A1B2C3, 32'h1A2B3C4D, 32'h0001E240, 0, 16'h0, 0, -1);

      for (int t = 0; t < 100 && exp_q.size() != 0; t++) idle(1);
      idle(3);
      chk("pending_events", exp_q.size(), 32'd0);
      check_held("final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gps_ubx_parser.md
Name: gps_ubx_parser

Overview:
- Receive-side counterpart of the UBX configuration transmit path. Consumes the byte stream from the GPS UART receiver and frames UBX packets.
- Validates each frame with the 8-bit Fletcher checksum.
- Decodes NAV-POSLLH, NAV-VELNED, ACK-ACK and ACK-NAK. Presents latched fields with one-cycle valid strobes to the navigation logic and the configuration sequencer.

Parameters:
- MAX_LEN, 64, largest payload length accepted. Frames with a longer declared length are dropped.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rx_data  input  8  received byte
- rx_valid  input  1  rx_data valid for one cycle; no backpressure, every strobe is consumed
- posllh_valid  output  1  one-cycle strobe: new lon/lat/hmsl committed
- lon  output  32  signed longitude, 1e-7 deg (payload bytes 4..7)
- lat  output  32  signed latitude, 1e-7 deg (bytes 8..11)
- hmsl  output  32  signed height MSL, mm (bytes 16..19)
- velned_valid  output  1  one-cycle strobe: new velocity committed
- vel_n  output  32  signed north velocity, cm/s (bytes 4..7)
- vel_e  output  32  signed east velocity, cm/s (bytes 8..11)
- vel_d  output  32  signed down velocity, cm/s (bytes 12..15)
- gspeed  output  32  ground speed, cm/s (bytes 20..23)
- ack_valid  output  1  one-cycle strobe: ACK or NAK received
- ack_nak  output  1  0 = ACK-ACK (05 01), 1 = ACK-NAK (05 00); held with ack fields
- ack_class  output  8  class of acknowledged message (payload byte 0)
- ack_id  output  8  id of acknowledged message (payload byte 1)
- cksum_err  output  1  one-cycle strobe: complete frame failed checksum
- frame_err  output  1  one-cycle strobe: declared length > MAX_LEN

Behaviour:
- Reset:
  - All outputs 0.
  - State SYNC1.
  - Checksum accumulators, byte counter and shadow registers 0.
- States: SYNC1, SYNC2, CLASS, ID, LEN_L, LEN_H, PAYLOAD, CK_A, CK_B. State changes only on cycles with rx_valid=1.
- SYNC1: 0xB5 -> SYNC2; any other byte stays in SYNC1.
- SYNC2: 0x62 -> CLASS; 0xB5 stays in SYNC2; any other byte -> SYNC1.
- CLASS -> ID -> LEN_L -> LEN_H. Length is 16-bit little-endian.
- On leaving LEN_H:
  - If len > MAX_LEN: pulse frame_err, go to SYNC1.
  - If len == 0: go to CK_A.
  - Otherwise: go to PAYLOAD with byte counter cleared.
- PAYLOAD: the counter increments per byte; after byte len-1 go to CK_A.
- Payload bytes are assembled little-endian into shadow registers by offset. Only offsets relevant to the current class/id are captured.
- Checksum:
  - Covers class, id, both length bytes and all payload bytes.
  - Per byte: A = A + byte; B = B + A (new A). Both are 8-bit and wrap mod 256.
  - A and B are cleared on entering CLASS.
- CK_A: compare rx byte with A, store match flag, go to CK_B.
- CK_B: compare with B, go to SYNC1.
- Commit on the CK_B edge:
  - If both checksum bytes match and (class,id,len) is one of (01,02,28), (01,12,36), (05,01,2) or (05,00,2): copy shadow to outputs and set the matching valid strobe.
  - Any checksum mismatch: pulse cksum_err and leave outputs unchanged.
  - Valid checksum but unknown id or wrong length: silently ignore.
- Strobe timing: strobes are registered, high for exactly the one cycle after the CK_B-accepting edge, and low otherwise, including cycles with rx_valid=0.
- Held outputs: data outputs hold their last committed value indefinitely. A partial or bad frame never corrupts them.
- Idle rx gaps (rx_valid=0) at any state are tolerated; the FSM holds.
- Resync: a stray 0xB5 inside a frame is treated as data. There is no mid-frame resync; recovery happens after CK_B or frame_err.
- rst asserted mid-frame returns to SYNC1 next edge; that partial frame produces no strobe.

Test Plan:
- ACK-ACK: send B5 62 05 01 02 00 06 01 0F 38 -> ack_valid high 1 cycle, ack_nak=0, ack_class=06, ack_id=01.
- ACK-NAK: send B5 62 05 00 02 00 06 01 0E 33 -> ack_valid pulse, ack_nak=1, class 06, id 01.
- POSLLH: bench-checksummed frame with lon=0xF8A1B2C3, lat=0x1A2B3C4D, hmsl=0x0001E240 -> posllh_valid single pulse, outputs equal those values; repeat with random rx_valid gaps, same result.
- Corrupt checksum: ACK frame ending 0F 39 -> cksum_err pulse, ack_valid stays 0, ack fields keep their prior values.
- Sync/length:
  - Garbage 00 B5 B5 62 followed by a valid VELNED frame (velN=-100 -> 0xFFFFFF9C, gSpeed=250) -> velned_valid, fields correct.
  - Header declaring len=0x0100 -> frame_err pulse, parser returns to SYNC1, next valid ACK is decoded.
- Reset mid-payload of POSLLH -> no strobe, all outputs 0; the subsequent full frame decodes correctly.
